ambaid_r_demux: RTL and testbench
=================================

# ambaid_r_demux

Read-response demultiplexer at the slave side of the Daric AXI fabric. Accepts one downstream AXI R channel and decodes the 4-bit AMBAID field carried in the top of RID. Routes each beat through a one-entry pipeline register to the originating master port: CM7A, VEXI, VEXD, SCEA, SCES, MDMA, CM7P, CM7D, VEXP, UDMA, UDCA or SDDC. Optionally tracks per-master outstanding reads from the AR channel, and flags orphan responses and counter overflow.

## Interface
Parameters:
- IW, 8, total RID/ARID width; AMBAID = id[IW-1 -: 4]
- DW, 64, RDATA width
- OTW, 4, outstanding-counter width per AMBAID code

Ports:
- aclk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- s_rvalid  in  1  upstream R valid
- s_rready  out  1  upstream R ready
- s_rid  in  IW  upstream RID
- s_rdata  in  DW  upstream RDATA
- s_rresp  in  2  upstream RRESP
- s_rlast  in  1  upstream RLAST
- m_rvalid  out  16  per-code valid, one-hot or zero, indexed by AMBAID
- m_rready  in  16  per-code ready
- m_rid / m_rdata / m_rresp / m_rlast  out  IW/DW/2/1  shared payload bus
- ar_valid, ar_ready  in  1  observed AR handshake (snoop only)
- ar_id  in  IW  observed ARID
- err_clr  in  1  clears sticky errors and drop_cnt
- err_unknown, err_orphan, err_ovf  out  1  sticky error flags
- drop_cnt  out  16  beats dropped for unknown AMBAID, saturating
- idle  out  1  stage empty and all outstanding counters zero

## Operation
- Valid codes: 0x2–0xD. Codes 0x0, 0x1, 0xE and 0xF are unknown.
- Pipeline stage: holds one beat plus a 4-bit code.
- s_rready = !full || m_rready[code_q].
- Beat is accepted when s_rvalid && s_rready.
- A beat with an unknown code is accepted whenever s_rready is high and is never loaded into the stage.
  - Sets err_unknown.
  - Increments drop_cnt, saturating at 0xFFFF.
- m_rvalid[code_q] = full. All other bits are 0. Payload outputs hold while full && !m_rready[code_q] (AXI stability rule).
- Stage pop and new load in the same cycle is allowed, giving full throughput.
- err_clr clears the flags and drop_cnt. If err_clr and a new error occur in the same cycle, the new error wins: the flag stays set and drop_cnt reads 1.

## Timing
- Latency: s_rvalid to m_rvalid is one cycle. Throughput is one beat per cycle with continuous m_rready.
- No combinational path from s_* to m_rvalid. The path from m_rready to s_rready is combinational.
- Reset values: full=0, m_rvalid=0, s_rready=1, all payload outputs 0, all flags 0, drop_cnt=0, all counters 0, idle=1.
- Reset mid-burst: the stage is emptied and counters are zeroed. Beats still in flight after reset raise err_orphan when tracking is on.

## Configuration
- AMBAID_OT_TRACK_EN defined:
  - 16 outstanding counters, each OTW bits.
  - +1 on an AR handshake for a valid code.
  - −1 when an s_rlast beat for that code is loaded into the stage.
  - Increment and decrement on the same code in the same cycle leave the count unchanged.
  - Increment at the maximum value (2^OTW−1): counter holds, err_ovf is set.
  - Decrement at 0: counter stays 0, err_orphan is set, the beat is still forwarded.
  - AR handshakes carrying an unknown code are ignored.
- AMBAID_OT_TRACK_EN undefined:
  - No counters; ar_* inputs are unused.
  - err_orphan and err_ovf are tied to 0.
  - idle = !full.

## Structure
- Shared package daric_cfg gains:
  - AMBAID4_VALID_MASK, a 16-bit constant, 0x3FFC.
  - Function ambaid_valid(bit [3:0]) returning bit.
  - Typedef ambaid_t = bit [3:0].
  - The existing AMBAID4_* codes remain the index source.
- One sub-module, ambaid_ot_cnt: a single saturating up/down counter with ovf and orphan pulses. It is instantiated 16 times under AMBAID_OT_TRACK_EN.

## Test plan
- Single beat, RID=0x40 (VEXD), m_rready=all ones → one cycle later m_rvalid=0x0010 with matching payload, then idle=1.
- 8-beat burst RID=0x9x while m_rready[9] toggles 1,0,0,1 → payload stable while stalled, no beats lost or duplicated, rlast arrives on beat 8.
- RID=0xE0 beat → s_rready=1, m_rvalid=0, err_unknown=1, drop_cnt=1; err_clr then returns both to 0.
- Tracking on: 15 ARs with code 0x2, then a 16th → err_ovf=1 and counter=15. Returning 15 rlast beats brings the counter to 0 and idle=1.
- Tracking on: rlast beat with code 0x7 and no prior AR → err_orphan=1, beat forwarded on m_rvalid[7].
- AR handshake and rlast for code 0xA in the same cycle, starting from count 1 → count remains 1.

Source files
------------

// File: rtl/daric_cfg_pkg.sv
// Shared Daric fabric configuration: AMBAID codes, their validity mask and
// a decode helper used by the read-response demultiplexer.
package daric_cfg;

  typedef bit [3:0] ambaid_t;

  // Master-port codes carried in the top four bits of AXI IDs
  localparam ambaid_t AMBAID4_CM7A = 4'h2;
  localparam ambaid_t AMBAID4_VEXI = 4'h3;
  localparam ambaid_t AMBAID4_VEXD = 4'h4;
  localparam ambaid_t AMBAID4_SCEA = 4'h5;
  localparam ambaid_t AMBAID4_SCES = 4'h6;
  localparam ambaid_t AMBAID4_MDMA = 4'h7;
  localparam ambaid_t AMBAID4_CM7P = 4'h8;
  localparam ambaid_t AMBAID4_CM7D = 4'h9;
  localparam ambaid_t AMBAID4_VEXP = 4'hA;
  localparam ambaid_t AMBAID4_UDMA = 4'hB;
  localparam ambaid_t AMBAID4_UDCA = 4'hC;
  localparam ambaid_t AMBAID4_SDDC = 4'hD;

  // Built from the codes themselves so the two can never drift (= 16'h3FFC)
  localparam bit [15:0] AMBAID4_VALID_MASK =
    (16'h1 << AMBAID4_CM7A) | (16'h1 << AMBAID4_VEXI) | (16'h1 << AMBAID4_VEXD) |
    (16'h1 << AMBAID4_SCEA) | (16'h1 << AMBAID4_SCES) | (16'h1 << AMBAID4_MDMA) |
    (16'h1 << AMBAID4_CM7P) | (16'h1 << AMBAID4_CM7D) | (16'h1 << AMBAID4_VEXP) |
    (16'h1 << AMBAID4_UDMA) | (16'h1 << AMBAID4_UDCA) | (16'h1 << AMBAID4_SDDC);

  function automatic bit ambaid_valid(bit [3:0] code);
    return AMBAID4_VALID_MASK[code];
  endfunction

endpackage

// File: rtl/ambaid_r_demux_ot_cnt.sv
// ambaid_ot_cnt: saturating up/down outstanding-read counter for one AMBAID
// code. Simultaneous inc and dec cancel. ovf/orphan are single-cycle pulses.
module ambaid_ot_cnt #(
  parameter int OTW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic ovf,
  output logic orphan
);

  localparam logic [OTW-1:0] CNT_MAX = '1;

  logic [OTW-1:0] cnt_q;

  // Saturation / underflow detection and empty indication
  always_comb begin
    zero   = (cnt_q == '0);
    ovf    = inc && !dec && (cnt_q == CNT_MAX);
    orphan = dec && !inc && (cnt_q == '0);
  end

  // Count register: holds at both limits
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && !dec && !ovf) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dec && !inc && !orphan) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/ambaid_r_demux.sv
// ambaid_r_demux: routes one AXI R channel to per-master ports by the AMBAID
// code in RID[IW-1 -: 4] through a one-entry pipeline register.
// Optional feature macro: AMBAID_OT_TRACK_EN (per-code outstanding tracking).
module ambaid_r_demux
  import daric_cfg::*;
#(
  parameter int IW  = 8,
  parameter int DW  = 64,
  parameter int OTW = 4
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          s_rvalid,
  output logic          s_rready,
  input  logic [IW-1:0] s_rid,
  input  logic [DW-1:0] s_rdata,
  input  logic [1:0]    s_rresp,
  input  logic          s_rlast,
  output logic [15:0]   m_rvalid,
  input  logic [15:0]   m_rready,
  output logic [IW-1:0] m_rid,
  output logic [DW-1:0] m_rdata,
  output logic [1:0]    m_rresp,
  output logic          m_rlast,
  input  logic          ar_valid,
  input  logic          ar_ready,
  input  logic [IW-1:0] ar_id,
  input  logic          err_clr,
  output logic          err_unknown,
  output logic          err_orphan,
  output logic          err_ovf,
  output logic [15:0]   drop_cnt,
  output logic          idle
);

  // Handshake: a beat transfers on any cycle where valid && ready; valid
  // never depends on ready, and payload is held while valid && !ready.

  logic          full_q;
  ambaid_t       code_q;
  logic [IW-1:0] rid_q;
  logic [DW-1:0] data_q;
  logic [1:0]    resp_q;
  logic          last_q;

  ambaid_t s_code;
  logic    pop, acc, load, drop;

  // Upstream accept/decode; ready passes m_rready straight through
  always_comb begin
    s_code   = s_rid[IW-1 -: 4];
    pop      = full_q && m_rready[code_q];
    s_rready = !full_q || m_rready[code_q];
    acc      = s_rvalid && s_rready;
    load     = acc && ambaid_valid(s_code);
    drop     = acc && !ambaid_valid(s_code);
  end

  // Pipeline stage: load wins over pop so back-to-back beats stream
  always_ff @(posedge aclk) begin
    if (areset) begin
      full_q <= 1'b0;
      code_q <= '0;
      rid_q  <= '0;
      data_q <= '0;
      resp_q <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      full_q <= 1'b1;
      code_q <= s_code;
      rid_q  <= s_rid;
      data_q <= s_rdata;
      resp_q <= s_rresp;
      last_q <= s_rlast;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

  // One-hot valid from registered state only
  always_comb begin
    m_rvalid         = '0;
    m_rvalid[code_q] = full_q;
    m_rid            = rid_q;
    m_rdata          = data_q;
    m_rresp          = resp_q;
    m_rlast          = last_q;
  end

  // Unknown-code drops: a new drop beats a simultaneous clear
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_unknown <= 1'b0;
      drop_cnt    <= '0;
    end else if (drop) begin
      err_unknown <= 1'b1;
      if (err_clr)
        drop_cnt <= 16'd1;
      else if (drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end else if (err_clr) begin
      err_unknown <= 1'b0;
      drop_cnt    <= '0;
    end
  end

`ifdef AMBAID_OT_TRACK_EN
  ambaid_t     ar_code;
  logic        ar_fire;
  logic [15:0] inc_vec, dec_vec, zero_vec, ovf_vec, orph_vec;
  logic        unused_ar_lo;

  assign ar_code      = ar_id[IW-1 -: 4];
  assign ar_fire      = ar_valid && ar_ready && ambaid_valid(ar_code);
  assign unused_ar_lo = ^ar_id[IW-5:0];

  for (genvar i = 0; i < 16; i++) begin : g_ot
    assign inc_vec[i] = ar_fire && (ar_code == 4'(i));
    assign dec_vec[i] = load && s_rlast && (s_code == 4'(i));

    ambaid_ot_cnt #(.OTW(OTW)) u_cnt (
      .clk    (aclk),
      .rst    (areset),
      .inc    (inc_vec[i]),
      .dec    (dec_vec[i]),
      .zero   (zero_vec[i]),
      .ovf    (ovf_vec[i]),
      .orphan (orph_vec[i])
    );
  end

  // Sticky tracking errors: a new event beats a simultaneous clear
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_ovf    <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (|ovf_vec)     err_ovf <= 1'b1;
      else if (err_clr) err_ovf <= 1'b0;
      if (|orph_vec)    err_orphan <= 1'b1;
      else if (err_clr) err_orphan <= 1'b0;
    end
  end

  assign idle = !full_q && (&zero_vec);
`else
  logic unused_ar;

  assign unused_ar  = ^{ar_valid, ar_ready, ar_id, {OTW{1'b0}}};
  assign err_orphan = 1'b0;
  assign err_ovf    = 1'b0;
  assign idle       = !full_q;
`endif

endmodule

// File: tb/tb_ambaid_r_demux.sv
// Directed bench for ambaid_r_demux: a vector table for single-cycle
// behaviour plus hand sequences for bursts, saturation, reset and tracking.
module tb_ambaid_r_demux;

  localparam int IW = 8;
  localparam int DW = 64;

  // clock / reset block
  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          s_rvalid = 1'b0;
  logic          s_rready;
  logic [IW-1:0] s_rid = '0;
  logic [DW-1:0] s_rdata = '0;
  logic [1:0]    s_rresp = '0;
  logic          s_rlast = 1'b0;
  logic [15:0]   m_rvalid;
  logic [15:0]   m_rready = '0;
  logic [IW-1:0] m_rid;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic          ar_valid = 1'b0;
  logic          ar_ready = 1'b0;
  logic [IW-1:0] ar_id = '0;
  logic          err_clr = 1'b0;
  logic          err_unknown, err_orphan, err_ovf;
  logic [15:0]   drop_cnt;
  logic          idle;

  always #5 aclk = ~aclk;

  ambaid_r_demux #(.IW(IW), .DW(DW), .OTW(4)) dut (
    .aclk(aclk), .areset(areset),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id),
    .err_clr(err_clr), .err_unknown(err_unknown), .err_orphan(err_orphan),
    .err_ovf(err_ovf), .drop_cnt(drop_cnt), .idle(idle)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard
  logic [DW:0] exp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // driver tasks
  task automatic ar_pulse(input logic [IW-1:0] id);
    ar_valid = 1'b1; ar_ready = 1'b1; ar_id = id;
    tick();
    ar_valid = 1'b0; ar_ready = 1'b0;
  endtask

  task automatic send_beat(input logic [IW-1:0] rid, input logic last);
    s_rvalid = 1'b1; s_rid = rid; s_rdata = 64'hC0DE_0000 | 64'(rid);
    s_rresp = 2'b00; s_rlast = last; m_rready = '1;
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  typedef struct {
    logic        vld;
    logic [7:0]  rid;
    logic [63:0] data;
    logic        last;
    logic [15:0] rdy;
    logic        clr;
    logic        exp_srdy;
    logic [15:0] exp_mv;
    logic [7:0]  exp_rid;
    logic [63:0] exp_data;
    logic        exp_last;
    logic        exp_unk;
    logic [15:0] exp_drop;
    logic        exp_idle;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  localparam logic [63:0] D0 = 64'h0;
  localparam logic [63:0] D1 = 64'h1111_2222_3333_4441;
  localparam logic [63:0] D2 = 64'h5555_6666_7777_88A2;
  localparam logic [63:0] D3 = 64'h9999_AAAA_BBBB_CCC3;
  localparam logic [63:0] D4 = 64'hDEAD_BEEF_0000_0000;
  localparam logic [63:0] D5 = 64'h0123_4567_89AB_CDE1;
  localparam logic [63:0] D6 = 64'hFEDC_BA98_7654_3212;

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [3:0]  pat;
    logic [DW:0] held, exp;
    logic        stalled;
    int          sent, got;

    //           vld rid  data last rdy      clr srdy mv        rid   data last unk drop   idle
    vecs[0]  = '{0, 8'h00, D0, 0, 16'hFFFF, 0, 1, 16'h0000, 8'h00, D0, 0, 0, 16'd0, 1};
    vecs[1]  = '{1, 8'h40, D1, 1, 16'hFFFF, 0, 1, 16'h0010, 8'h40, D1, 1, 0, 16'd0, 0};
    vecs[2]  = '{0, 8'h00, D0, 0, 16'hFFFF, 0, 1, 16'h0000, 8'h40, D1, 1, 0, 16'd0, 1};
    vecs[3]  = '{1, 8'h25, D2, 0, 16'h0000, 0, 1, 16'h0004, 8'h25, D2, 0, 0, 16'd0, 0};
    vecs[4]  = '{1, 8'h31, D3, 1, 16'h0000, 0, 0, 16'h0004, 8'h25, D2, 0, 0, 16'd0, 0};
    vecs[5]  = '{1, 8'h31, D3, 1, 16'h0004, 0, 1, 16'h0008, 8'h31, D3, 1, 0, 16'd0, 0};
    vecs[6]  = '{1, 8'hE0, D4, 1, 16'h0008, 0, 1, 16'h0000, 8'h31, D3, 1, 1, 16'd1, 1};
    vecs[7]  = '{1, 8'h05, D4, 0, 16'h0000, 0, 1, 16'h0000, 8'h31, D3, 1, 1, 16'd2, 1};
    vecs[8]  = '{1, 8'hF3, D4, 0, 16'h0000, 1, 1, 16'h0000, 8'h31, D3, 1, 1, 16'd1, 1};
    vecs[9]  = '{0, 8'h00, D0, 0, 16'h0000, 1, 1, 16'h0000, 8'h31, D3, 1, 0, 16'd0, 1};
    vecs[10] = '{1, 8'hD7, D5, 1, 16'h0000, 0, 1, 16'h2000, 8'hD7, D5, 1, 0, 16'd0, 0};
    vecs[11] = '{1, 8'hF0, D4, 0, 16'h0000, 0, 0, 16'h2000, 8'hD7, D5, 1, 0, 16'd0, 0};
    vecs[12] = '{1, 8'hF0, D4, 0, 16'h2000, 0, 1, 16'h0000, 8'hD7, D5, 1, 1, 16'd1, 1};
    vecs[13] = '{0, 8'h00, D0, 0, 16'h0000, 1, 1, 16'h0000, 8'hD7, D5, 1, 0, 16'd0, 1};
    vecs[14] = '{1, 8'h7F, D6, 0, 16'hFFFF, 0, 1, 16'h0080, 8'h7F, D6, 0, 0, 16'd0, 0};
    vecs[15] = '{0, 8'h00, D0, 0, 16'hFF7F, 0, 0, 16'h0080, 8'h7F, D6, 0, 0, 16'd0, 0};
    vecs[16] = '{0, 8'h00, D0, 0, 16'hFFFF, 0, 1, 16'h0000, 8'h7F, D6, 0, 0, 16'd0, 1};

    // reset state
    repeat (3) tick();
    areset = 1'b0;
    check("rst_s_rready", s_rready, 1);
    check("rst_m_rvalid", m_rvalid, 0);
    check("rst_m_rid", m_rid, 0);
    check("rst_m_rdata", m_rdata, 0);
    check("rst_flags", {err_unknown, err_orphan, err_ovf}, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_idle", idle, 1);

    // vector table
    for (int k = 0; k < NV; k++) begin
      s_rvalid = vecs[k].vld;
      s_rid    = vecs[k].rid;
      s_rdata  = vecs[k].data;
      s_rresp  = vecs[k].data[1:0];
      s_rlast  = vecs[k].last;
      m_rready = vecs[k].rdy;
      err_clr  = vecs[k].clr;
      #1;
      check($sformatf("v%0d_s_rready", k), s_rready, vecs[k].exp_srdy);
      tick();
      check($sformatf("v%0d_m_rvalid", k), m_rvalid, vecs[k].exp_mv);
      check($sformatf("v%0d_m_rid", k), m_rid, vecs[k].exp_rid);
      check($sformatf("v%0d_m_rdata", k), m_rdata, vecs[k].exp_data);
      check($sformatf("v%0d_m_rresp", k), m_rresp, vecs[k].exp_data[1:0]);
      check($sformatf("v%0d_m_rlast", k), m_rlast, vecs[k].exp_last);
      check($sformatf("v%0d_err_unknown", k), err_unknown, vecs[k].exp_unk);
      check($sformatf("v%0d_drop_cnt", k), drop_cnt, vecs[k].exp_drop);
      check($sformatf("v%0d_idle", k), idle, vecs[k].exp_idle);
    end
    s_rvalid = 1'b0; err_clr = 1'b0; m_rready = '1;
    tick();

`ifndef AMBAID_OT_TRACK_EN
    // without tracking, AR traffic must not affect idle and errors stay 0
    ar_pulse(8'h20);
    check("notrk_idle", idle, 1);
    check("notrk_err_orphan", err_orphan, 0);
    check("notrk_err_ovf", err_ovf, 0);
`endif

    // 8-beat burst to code 9 with m_rready[9] pattern 1,0,0,1
    pat = 4'b1001;
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 64 && got < 8; cyc++) begin
      s_rvalid = (sent < 8);
      s_rid    = 8'h90 + 8'(sent);
      s_rdata  = 64'hB000 + 64'(sent);
      s_rresp  = 2'b00;
      s_rlast  = (sent == 7);
      m_rready = pat[cyc % 4] ? 16'h0200 : 16'h0000;
      #1;
      if (stalled) begin
        check("burst_hold_valid", m_rvalid, 16'h0200);
        check("burst_hold_payload", {m_rlast, m_rdata}, held);
      end
      if (m_rvalid[9] && m_rready[9]) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("burst_beat", {m_rlast, m_rdata}, exp);
        got++;
        stalled = 1'b0;
      end else if (m_rvalid[9]) begin
        stalled = 1'b1;
        held = {m_rlast, m_rdata};
      end else begin
        stalled = 1'b0;
      end
      if (s_rvalid && s_rready) begin
        exp_q.push_back({s_rlast, s_rdata});
        sent++;
      end
      tick();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    check("burst_count", got, 8);
    check("burst_queue_empty", exp_q.size(), 0);
    m_rready = '1;
    tick();
    check("burst_idle", idle, 1);

    // reset mid-flight empties the stage
    s_rvalid = 1'b1; s_rid = 8'h55; s_rdata = 64'h5A5A; s_rlast = 1'b0; m_rready = '0;
    tick();
    s_rvalid = 1'b0;
    check("midrst_loaded", m_rvalid, 16'h0020);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("midrst_m_rvalid", m_rvalid, 0);
    check("midrst_m_rdata", m_rdata, 0);
    check("midrst_s_rready", s_rready, 1);
    check("midrst_idle", idle, 1);

    // drop_cnt saturation at 0xFFFF
    s_rvalid = 1'b1; s_rid = 8'hE0; s_rdata = '0; m_rready = '0;
    repeat (65535) @(posedge aclk);
    #1;
    check("sat_drop_cnt_max", drop_cnt, 16'hFFFF);
    tick();
    check("sat_drop_cnt_hold", drop_cnt, 16'hFFFF);
    check("sat_err_unknown", err_unknown, 1);
    check("sat_m_rvalid", m_rvalid, 0);
    s_rvalid = 1'b0;
    clear_errors();
    check("sat_clr_drop_cnt", drop_cnt, 0);
    check("sat_clr_err_unknown", err_unknown, 0);

`ifdef AMBAID_OT_TRACK_EN
    areset = 1'b1;
    tick();
    areset = 1'b0;
    m_rready = '1;
    // 15 ARs fill code 2, the 16th overflows
    for (int k = 0; k < 15; k++) ar_pulse(8'h2C);
    check("ot_ovf_before", err_ovf, 0);
    check("ot_idle_busy", idle, 0);
    ar_pulse(8'h2C);
    check("ot_ovf_after", err_ovf, 1);
    for (int k = 0; k < 15; k++) send_beat(8'h21, 1'b1);
    tick();
    check("ot_drain_idle", idle, 1);
    check("ot_drain_no_orphan", err_orphan, 0);
    send_beat(8'h21, 1'b1);
    tick();
    check("ot_sixteenth_orphan", err_orphan, 1);
    clear_errors();
    check("ot_clr_orphan", err_orphan, 0);
    check("ot_clr_ovf", err_ovf, 0);

    // orphan beat on code 7 is still forwarded
    send_beat(8'h70, 1'b1);
    check("ot_orphan7_fwd", m_rvalid, 16'h0080);
    check("ot_orphan7_flag", err_orphan, 1);
    tick();
    clear_errors();

    // unknown-code AR is ignored
    ar_pulse(8'hF0);
    check("ot_unknown_ar_idle", idle, 1);

    // simultaneous inc and dec on code A from count 1
    ar_pulse(8'hA5);
    check("ot_a_busy", idle, 0);
    ar_valid = 1'b1; ar_ready = 1'b1; ar_id = 8'hA5;
    s_rvalid = 1'b1; s_rid = 8'hA3; s_rlast = 1'b1; m_rready = '1;
    tick();
    ar_valid = 1'b0; ar_ready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    tick();
    check("ot_a_still_one", idle, 0);
    check("ot_a_no_orphan", err_orphan, 0);
    send_beat(8'hA3, 1'b1);
    tick();
    check("ot_a_drained", idle, 1);
    check("ot_a_drained_no_orphan", err_orphan, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
